// File: rtl/transmitor.sv
// PN source -> Hamming(7,4) encoder -> serial channel with optional single-bit error -> syndrome decoder.
// Decoded bits appear on decoder_out two frames after capture; IsTransmit=0 freezes every register.
module transmitor #(
  parameter logic [6:0] LFSR_SEED = 7'h7F,
  parameter int         ERR_START = 1
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic init_tab,
  input  logic has_error,
  input  logic IsTransmit,
  output logic decoder_out
);

  logic [2:0] fc;
  logic [6:0] lfsr;
  logic [3:0] data;
  logic [2:0] err_pos;
  logic [6:0] tx;
  logic [5:0] rx;
  logic [3:0] dout_word;
  logic [6:0] tab [8];

  logic       tab_load;
  logic [6:0] cw;
  logic [6:0] err_mask;
  logic       chan_bit;
  logic [6:0] rx_word;
  logic [2:0] syn;
  logic [6:0] corr;
  logic [3:0] dec;

  assign tab_load = reset | init_tab;

  // Bit index i holds codeword position i+1: p1,p2,d1,p4,d2,d3,d4
  assign cw[0] = data[0] ^ data[1] ^ data[3];
  assign cw[1] = data[0] ^ data[2] ^ data[3];
  assign cw[2] = data[0];
  assign cw[3] = data[1] ^ data[2] ^ data[3];
  assign cw[4] = data[1];
  assign cw[5] = data[2];
  assign cw[6] = data[3];

  assign err_mask = has_error ? 7'(7'b1 << (err_pos - 3'd1)) : 7'b0;

  assign chan_bit = tx[fc];
  assign rx_word  = {chan_bit, rx};

  assign syn[0] = rx_word[0] ^ rx_word[2] ^ rx_word[4] ^ rx_word[6];
  assign syn[1] = rx_word[1] ^ rx_word[2] ^ rx_word[5] ^ rx_word[6];
  assign syn[2] = rx_word[3] ^ rx_word[4] ^ rx_word[5] ^ rx_word[6];

  assign corr = rx_word ^ tab[syn];
  assign dec  = {corr[6], corr[5], corr[4], corr[2]};

  // Table is level-loaded while reset or init_tab is high, otherwise retained
  always_ff @(posedge sys_clk or posedge tab_load) begin
    if (tab_load) begin
      tab[0] <= 7'b0;
      for (int i = 1; i < 8; i++) begin
        tab[i] <= 7'(7'b1 << (i - 1));
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        tab[i] <= tab[i];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      fc          <= 3'd0;
      lfsr        <= LFSR_SEED;
      data        <= 4'b0;
      err_pos     <= 3'(ERR_START);
      tx          <= 7'b0;
      rx          <= 6'b0;
      dout_word   <= 4'b0;
      decoder_out <= 1'b0;
    end else if (IsTransmit) begin
      fc <= (fc == 3'd6) ? 3'd0 : fc + 3'd1;

      if (fc <= 3'd3) begin
        data[fc[1:0]] <= lfsr[6];
        lfsr          <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      end

      if (fc != 3'd6) begin
        rx[fc] <= chan_bit;
      end

      // Frame boundary: latch next codeword, decode received one, start serial output
      if (fc == 3'd6) begin
        tx          <= cw ^ err_mask;
        if (has_error) begin
          err_pos <= (err_pos == 3'd7) ? 3'd1 : err_pos + 3'd1;
        end
        dout_word   <= dec;
        decoder_out <= dec[0];
      end else if (fc <= 3'd2) begin
        decoder_out <= dout_word[fc[1:0] + 2'd1];
      end else begin
        decoder_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_transmitor.sv
// Bench for transmitor: reference PN stream indexed by run-cycle count predicts decoder_out every cycle.
module tb_transmitor;

  logic clk = 1'b0;
  logic reset;
  logic init_tab;
  logic has_error;
  logic IsTransmit;
  logic decoder_out;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;
  logic lit_en = 1'b0;

  logic       src_bits [2048];
  logic [0:41] lit_vec;

  transmitor dut (
    .sys_clk    (clk),
    .reset      (reset),
    .init_tab   (init_tab),
    .has_error  (has_error),
    .IsTransmit (IsTransmit),
    .decoder_out(decoder_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d time=%0t: got %b expected %b", name, t, $time, act, exp);
    end
  endtask

  // Cycle t of a run: frames 0,1 silent; frame f>=2 slots 0..3 carry source bits of frame f-2
  function automatic logic model_bit(input int cyc);
    int f, s, idx;
    f = cyc / 7;
    s = cyc % 7;
    if (f < 2 || s > 3) return 1'b0;
    idx = (f - 2) * 4 + s;
    if (idx >= 2048) return 1'b0;
    return src_bits[idx];
  endfunction

  initial begin
    logic [6:0] l;
    l = 7'h7F;
    for (int i = 0; i < 2048; i++) begin
      src_bits[i] = l[6];
      l = {l[5:0], l[6] ^ l[5]};
    end
    // Hand-derived first six frames after reset from seed 7F
    lit_vec = 42'b0000000_0000000_1111000_1110000_0000000_0100000;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) t = 0;
    else if (IsTransmit) t = t + 1;
  end

  always @(negedge clk) begin
    chk("stream", decoder_out, reset ? 1'b0 : model_bit(t));
    if (lit_en && !reset && t < 42) chk("literal", decoder_out, lit_vec[t]);
  end

  initial begin
    bit found;
    reset      = 1'b1;
    init_tab   = 1'b0;
    has_error  = 1'b0;
    IsTransmit = 1'b1;

    repeat (4) @(negedge clk);
    #1 reset = 1'b0;
    lit_en = 1'b1;
    repeat (700) @(negedge clk);
    lit_en = 1'b0;

    // Error-injection run from a fresh reset
    #1 reset = 1'b1;
    has_error = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (700) @(negedge clk);

    // Freeze mid-frame
    repeat (3) @(negedge clk);
    #1 IsTransmit = 1'b0;
    repeat (10) @(negedge clk);
    #1 IsTransmit = 1'b1;
    repeat (70) @(negedge clk);

    // Async reset between edges while decoder_out is high
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #2;
      if (decoder_out === 1'b1) found = 1'b1;
    end
    chk("find_high_output", found, 1'b1);
    reset = 1'b1;
    #1 chk("async_reset", decoder_out, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    has_error = 1'b0;
    repeat (210) @(negedge clk);

    // init_tab pulse between edges, with errors on
    has_error = 1'b1;
    @(posedge clk);
    #2 init_tab = 1'b1;
    #2 init_tab = 1'b0;
    repeat (140) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/transmitor.md
Name: transmitor

Overview:
- Self-contained digital transmission loop for the communication experiment.
- Data path: PN (LFSR) bit source, Hamming(7,4) encoder, serial channel with optional single-bit error injection, syndrome-table Hamming decoder.
- The decoded bit stream is driven serially on decoder_out.
- With single-bit errors only, decoder_out must reproduce the source sequence exactly, delayed by two frames.

Parameters:
- LFSR_SEED, 7'h7F, LFSR value loaded on reset.
- ERR_START, 1, first codeword position (1..7) corrupted after reset.

Ports:
- sys_clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- init_tab  input  1  asynchronous active-high load of the syndrome lookup table.
- has_error  input  1  1 = inject one bit error per codeword.
- IsTransmit  input  1  1 = run; 0 = freeze all state.
- decoder_out  output  1  registered serial decoded data.

Behaviour:
- Frame timing
  - Frame = 7 cycles; slot counter fc counts 0..6 and wraps.
  - fc advances only when IsTransmit=1.
  - When IsTransmit=0, every register (including decoder_out) holds.
- Source
  - 7-bit LFSR, polynomial x^7+x^6+1; out bit = lfsr[6]; next = {lfsr[5:0], lfsr[6]^lfsr[5]}.
  - LFSR shifts only in slots 0..3. Bits enter data d1..d4 in order (d1 first).
- Encoder, latched on the edge ending slot 6
  - Codeword positions 1..7 = p1,p2,d1,p4,d2,d3,d4.
  - p1=d1^d2^d4, p2=d1^d3^d4, p4=d2^d3^d4.
- Error injection
  - If has_error=1 at that edge, invert position err_pos, then err_pos advances 1→2→…→7→1.
  - If has_error=0, err_pos holds.
- Channel
  - In the next frame, slot j transmits position j+1 (position 1 first) into a receive shift register.
- Decoder, on the edge ending slot 6 of the receive frame
  - Use the 6 stored bits plus the current channel bit.
  - Syndrome s = {s4,s2,s1}, each the XOR over positions whose index has that bit set.
  - Table maps s → one-hot 7-bit correction mask; s=0 → no correction.
  - Corrected d1..d4 are latched into the output register.
- Output
  - In the following frame, decoder_out = d1,d2,d3,d4 during slots 0..3 and 0 during slots 4..6.
  - Each value is valid for the whole slot: the flop is updated at the edge that starts the slot.
  - Source bits captured in frame k appear on decoder_out in frame k+2.
- Syndrome table
  - Loaded with the standard Hamming map (entry s = bit for position s) asynchronously whenever init_tab=1 or reset=1.
  - Otherwise retained.
- Reset (asynchronous, while high)
  - fc=0, lfsr=LFSR_SEED, err_pos=ERR_START.
  - Data, tx, rx and output registers=0; decoder_out=0; table loaded.
  - Reset mid-frame discards all in-flight words.
  - After release, the first two frames output 0.
- Simultaneous init_tab and reset: both load the table; no conflict.
- Double-bit errors cannot occur by design (one flip per codeword).
- Tx and rx are double-buffered: encoding of frame k+1 overlaps transmission of frame k without corruption.

Test Plan:
- Reset state: hold reset=1 for several clocks → decoder_out=0 and state frozen. Release with IsTransmit=1 → decoder_out=0 for cycles 0..13.
- First word: seed 7'h7F gives source bits 1,1,1,1 → codeword 1111111 → decoder_out=1,1,1,1 in cycles 14..17, then 0 in cycles 18..20.
- No-error loopback: has_error=0, run 100 frames → decoder_out slots 0..3 of frame k+2 equal the reference LFSR bits of frame k; slots 4..6 are always 0.
- Error injection: has_error=1, run 100 frames → identical output to the no-error run. Internal codeword differs in exactly one position, cycling 1..7.
- Freeze: drop IsTransmit for 10 cycles mid-frame → decoder_out and all state hold; the stream resumes seamlessly.
- Async reset and init_tab: assert reset mid-frame between clock edges → decoder_out=0 immediately and the sequence restarts from the seed. Pulse init_tab alone between edges → data stream unaffected.
